control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Fetch/decode/execute sequencer that drives the ALU select interface (select, num_rotate)
//  and the datapath strobes around it: accumulator load, register-file write, immediate mux.
//  Fetches 8-bit instructions from program memory over a req/valid handshake.
//  Sits between program memory and the accumulator/register-file/ALU datapath.
// PARAMETERS
//  PC_W     8   program-counter / instruction-address width; PC wraps modulo 2**PC_W
// PORTS
//  clk          in   1     system clock, all state on rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  imem_req     out  1     fetch request; held high until imem_valid
//  imem_addr    out  PC_W  fetch address (current PC)
//  imem_valid   in   1     imem_rdata valid; sampled only while imem_req=1
//  imem_rdata   in   8     instruction or immediate byte
//  acc_zero     in   1     accumulator == 0 (from datapath)
//  alu_sel      out  4     ALU operation select
//  alu_rot      out  2     ALU rotate-right amount
//  imm_sel      out  1     1: ALU in1 = imm, 0: in1 = register file
//  imm          out  8     latched immediate byte
//  rf_addr      out  4     register-file index (instr[3:0])
//  acc_we       out  1     accumulator load strobe, 1 cycle
//  rf_we        out  1     register-file write strobe, 1 cycle
//  halted       out  1     sticky, set by HLT
//  illegal      out  1     1-cycle pulse on undefined opcode
// BEHAVIOUR
//  Opcode = instr[7:4]; op = instr[3:0]. ALU codes: PASS0=0000 AND=0001 OR=0010 ADD=0011
//  SUB=0100 INC=0101 DEC=0110 ROR=0111 SLT=1000 PASS1=1001.
//  0 NOP | 1 LDA Rn acc<=Rn (PASS1) | 2 STA Rn Rn<=acc (PASS0,rf_we) | 3 AND | 4 OR | 5 ADD
//  6 SUB | A SLT (all Rn, acc_we) | 7 INC | 8 DEC (acc_we) | 9 ROR alu_rot=op[1:0] (acc_we)
//  B LDI #b acc<=b (PASS1, imm_sel=1) | C JMP a pc<=a | D JZ a pc<=a if acc_zero | F HLT
//  E: illegal -> illegal pulse, treated as NOP. B/C/D are two-byte; byte 2 at pc+1.
//  States: FETCH -> DECODE -> [FETCH_IMM] -> EXECUTE -> FETCH; HLT -> HALT (terminal).
//  FETCH: imem_req=1, imem_addr=pc; on imem_valid latch ir, pc<=pc+1, go DECODE.
//   No valid -> stay, req and addr held stable.
//  DECODE: 1 cycle; two-byte ops -> FETCH_IMM, HLT -> HALT, else EXECUTE.
//  FETCH_IMM: same handshake; latch imm<=imem_rdata, pc<=pc+1.
//  EXECUTE: 1 cycle; alu_sel/alu_rot/imm_sel/rf_addr valid whole cycle; acc_we/rf_we high
//   this cycle only; datapath captures at end of EXECUTE. JMP/JZ update pc here.
//   JZ samples acc_zero in EXECUTE.
//  Latency: 1-byte op = fetch wait + 3 cycles; 2-byte op = 2 fetch waits + 4 cycles.
//   With zero-wait memory (valid same cycle as req) these are 3 and 4 cycles.
//  Outside EXECUTE: alu_sel=0000, alu_rot=0, imm_sel=0, acc_we=rf_we=0.
//  Reset (any state, async): state=FETCH, pc=0, ir=0, imm=0, all outputs 0 (imem_req=0)
//   while rst_n=0. imem_req rises the first clock after release. Memory drops in-flight
//   responses on reset; valid seen with req=0 is ignored.
//  PC wrap: 2**PC_W-1 + 1 -> 0, including the immediate fetch of a 2-byte op at the last address.
//  HALT: imem_req=0, strobes 0, halted=1 until rst_n.
// STRUCTURE
//  Shared package: opcode localparams, ALU select codes (shared with alu), FSM state encoding.
//  Sub-module control_decode (combinational): ir -> alu_sel, alu_rot, acc_we/rf_we enables,
//   imm_sel, two_byte, is_jmp, is_jz, is_hlt, is_illegal. FSM and PC stay in control_unit.
// TESTING
//  1. Zero-wait mem [B0 05 50 21 F0], R0=3 -> LDI acc=5 (PASS1, imm_sel); ADD R0 acc=8 (0011);
//     STA R1 rf_we, rf_addr=1; halted=1, imem_req=0.
//  2. valid delayed 3 cycles per fetch on [70] -> req/addr stable while waiting;
//     alu_sel=0101, acc_we exactly 1 cycle.
//  3. [D0 10] with acc_zero=1 -> pc=0x10; acc_zero=0 -> pc=0x02. [C0 80] -> pc=0x80.
//  4. [93] -> alu_sel=0111, alu_rot=3. [E5] -> illegal pulse 1 cycle, no strobes, next fetch at pc=1.
//  5. pc=0xFF holding B0, immediate at 0x00 -> imm fetched from 0x00, next fetch at 0x01.
//  6. rst_n low mid FETCH_IMM and mid EXECUTE -> outputs 0 immediately, no acc_we/rf_we glitch;
//     first fetch after release from addr 0.

Source files
------------

// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - opcodes, ALU select codes and FSM states for the sequencer
package control_unit_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_STA = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_ADD = 4'h5;
   localparam logic [3:0] OP_SUB = 4'h6;
   localparam logic [3:0] OP_INC = 4'h7;
   localparam logic [3:0] OP_DEC = 4'h8;
   localparam logic [3:0] OP_ROR = 4'h9;
   localparam logic [3:0] OP_SLT = 4'hA;
   localparam logic [3:0] OP_LDI = 4'hB;
   localparam logic [3:0] OP_JMP = 4'hC;
   localparam logic [3:0] OP_JZ  = 4'hD;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Shared with the ALU; values must not drift from its decoder.
   localparam logic [3:0] ALU_PASS0 = 4'b0000;
   localparam logic [3:0] ALU_AND   = 4'b0001;
   localparam logic [3:0] ALU_OR    = 4'b0010;
   localparam logic [3:0] ALU_ADD   = 4'b0011;
   localparam logic [3:0] ALU_SUB   = 4'b0100;
   localparam logic [3:0] ALU_INC   = 4'b0101;
   localparam logic [3:0] ALU_DEC   = 4'b0110;
   localparam logic [3:0] ALU_ROR   = 4'b0111;
   localparam logic [3:0] ALU_SLT   = 4'b1000;
   localparam logic [3:0] ALU_PASS1 = 4'b1001;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_FETCH_IMM,
      ST_EXECUTE,
      ST_HALT
   } state_e;

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational instruction decode into ALU selects and datapath enables
module control_decode
   import control_unit_pkg::*;
(
   input  logic [7:0] ir_i,
   output logic [3:0] alu_sel_o,
   output logic [1:0] alu_rot_o,
   output logic       acc_we_o,
   output logic       rf_we_o,
   output logic       imm_sel_o,
   output logic       two_byte_o,
   output logic       is_jmp_o,
   output logic       is_jz_o,
   output logic       is_hlt_o,
   output logic       is_illegal_o
);

   always_comb begin
      alu_sel_o    = ALU_PASS0;
      alu_rot_o    = 2'd0;
      acc_we_o     = 1'b0;
      rf_we_o      = 1'b0;
      imm_sel_o    = 1'b0;
      two_byte_o   = 1'b0;
      is_jmp_o     = 1'b0;
      is_jz_o      = 1'b0;
      is_hlt_o     = 1'b0;
      is_illegal_o = 1'b0;
      case (ir_i[7:4])
         OP_NOP: ;
         OP_LDA: begin alu_sel_o = ALU_PASS1; acc_we_o = 1'b1; end
         OP_STA: begin alu_sel_o = ALU_PASS0; rf_we_o  = 1'b1; end
         OP_AND: begin alu_sel_o = ALU_AND;   acc_we_o = 1'b1; end
         OP_OR:  begin alu_sel_o = ALU_OR;    acc_we_o = 1'b1; end
         OP_ADD: begin alu_sel_o = ALU_ADD;   acc_we_o = 1'b1; end
         OP_SUB: begin alu_sel_o = ALU_SUB;   acc_we_o = 1'b1; end
         OP_SLT: begin alu_sel_o = ALU_SLT;   acc_we_o = 1'b1; end
         OP_INC: begin alu_sel_o = ALU_INC;   acc_we_o = 1'b1; end
         OP_DEC: begin alu_sel_o = ALU_DEC;   acc_we_o = 1'b1; end
         OP_ROR: begin
            alu_sel_o = ALU_ROR;
            alu_rot_o = ir_i[1:0];
            acc_we_o  = 1'b1;
         end
         OP_LDI: begin
            alu_sel_o  = ALU_PASS1;
            imm_sel_o  = 1'b1;
            acc_we_o   = 1'b1;
            two_byte_o = 1'b1;
         end
         OP_JMP: begin two_byte_o = 1'b1; is_jmp_o = 1'b1; end
         OP_JZ:  begin two_byte_o = 1'b1; is_jz_o  = 1'b1; end
         OP_HLT: is_hlt_o = 1'b1;
         default: is_illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - fetch/decode/execute sequencer driving ALU selects and datapath strobes
module control_unit
   import control_unit_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [7:0]      imem_rdata,
   input  logic            acc_zero,
   output logic [3:0]      alu_sel,
   output logic [1:0]      alu_rot,
   output logic            imm_sel,
   output logic [7:0]      imm,
   output logic [3:0]      rf_addr,
   output logic            acc_we,
   output logic            rf_we,
   output logic            halted,
   output logic            illegal
);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [7:0]      ir_q, ir_d;
   logic [7:0]      imm_q, imm_d;
   // Holds imem_req low for the first clock after reset release.
   logic            run_q;

   logic [3:0] dec_alu_sel;
   logic [1:0] dec_alu_rot;
   logic       dec_acc_we, dec_rf_we, dec_imm_sel, dec_two_byte;
   logic       dec_is_jmp, dec_is_jz, dec_is_hlt, dec_is_illegal;

   control_decode u_decode (
      .ir_i         (ir_q),
      .alu_sel_o    (dec_alu_sel),
      .alu_rot_o    (dec_alu_rot),
      .acc_we_o     (dec_acc_we),
      .rf_we_o      (dec_rf_we),
      .imm_sel_o    (dec_imm_sel),
      .two_byte_o   (dec_two_byte),
      .is_jmp_o     (dec_is_jmp),
      .is_jz_o      (dec_is_jz),
      .is_hlt_o     (dec_is_hlt),
      .is_illegal_o (dec_is_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         pc_q    <= '0;
         ir_q    <= 8'h00;
         imm_q   <= 8'h00;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         imm_q   <= imm_d;
         run_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      imm_d    = imm_q;
      imem_req = 1'b0;
      alu_sel  = ALU_PASS0;
      alu_rot  = 2'd0;
      imm_sel  = 1'b0;
      acc_we   = 1'b0;
      rf_we    = 1'b0;
      illegal  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            imem_req = run_q;
            if (run_q && imem_valid) begin
               ir_d    = imem_rdata;
               pc_d    = pc_q + PC_W'(1);
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (dec_is_hlt)        state_d = ST_HALT;
            else if (dec_two_byte) state_d = ST_FETCH_IMM;
            else                   state_d = ST_EXECUTE;
         end
         ST_FETCH_IMM: begin
            imem_req = 1'b1;
            if (imem_valid) begin
               imm_d   = imem_rdata;
               pc_d    = pc_q + PC_W'(1);
               state_d = ST_EXECUTE;
            end
         end
         ST_EXECUTE: begin
            alu_sel = dec_alu_sel;
            alu_rot = dec_alu_rot;
            imm_sel = dec_imm_sel;
            acc_we  = dec_acc_we;
            rf_we   = dec_rf_we;
            illegal = dec_is_illegal;
            if (dec_is_jmp || (dec_is_jz && acc_zero)) pc_d = PC_W'(imm_q);
            state_d = ST_FETCH;
         end
         ST_HALT: ;
         default: state_d = ST_FETCH;
      endcase
   end

   assign imem_addr = pc_q;
   assign imm       = imm_q;
   assign rf_addr   = ir_q[3:0];
   assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed-vector bench for control_unit with memory and datapath models
module tb_control_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_valid;
   logic [7:0] imem_rdata;
   logic       acc_zero;
   logic [3:0] alu_sel;
   logic [1:0] alu_rot;
   logic       imm_sel;
   logic [7:0] imm;
   logic [3:0] rf_addr;
   logic       acc_we, rf_we, halted, illegal;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [256];
   int         wait_n;
   int         wcnt;
   logic       az_ovr, az_val;
   logic [7:0] acc;
   logic [7:0] rf [16];
   logic [7:0] in1, alu_y;

   int acc_log[$];
   int rf_log[$];
   int fetch_log[$];
   int ill_cnt = 0;

   always #5 clk = ~clk;

   control_unit #(.PC_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_rdata (imem_rdata),
      .acc_zero   (acc_zero),
      .alu_sel    (alu_sel),
      .alu_rot    (alu_rot),
      .imm_sel    (imm_sel),
      .imm        (imm),
      .rf_addr    (rf_addr),
      .acc_we     (acc_we),
      .rf_we      (rf_we),
      .halted     (halted),
      .illegal    (illegal)
   );

   assign imem_valid = imem_req && (wcnt >= wait_n);
   assign imem_rdata = mem[imem_addr];
   assign acc_zero   = az_ovr ? az_val : (acc == 8'h00);

   always @(posedge clk) begin
      if (imem_req && !imem_valid) wcnt <= wcnt + 1;
      else                         wcnt <= 0;
   end

   function automatic logic [7:0] alu(input logic [3:0] s, input logic [7:0] a,
                                      input logic [7:0] b, input logic [1:0] r);
      logic [15:0] t;
      t = {a, a} >> r;
      case (s)
         4'd0: return a;
         4'd1: return a & b;
         4'd2: return a | b;
         4'd3: return a + b;
         4'd4: return a - b;
         4'd5: return a + 8'd1;
         4'd6: return a - 8'd1;
         4'd7: return t[7:0];
         4'd8: return (a < b) ? 8'd1 : 8'd0;
         4'd9: return b;
         default: return 8'h00;
      endcase
   endfunction

   assign in1   = imm_sel ? imm : rf[rf_addr];
   assign alu_y = alu(alu_sel, acc, in1, alu_rot);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= 8'h00;
         for (int i = 0; i < 16; i++) rf[i] <= (i == 0) ? 8'd3 : 8'd0;
      end else begin
         if (acc_we) acc <= alu_y;
         if (rf_we)  rf[rf_addr] <= alu_y;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (acc_we) acc_log.push_back(int'(alu_sel) * 256 + int'(alu_rot) * 16 + int'(imm_sel));
         if (rf_we)  rf_log.push_back(int'(alu_sel) * 256 + int'(rf_addr));
         if (imem_req && imem_valid) fetch_log.push_back(int'(imem_addr));
         if (illegal) ill_cnt = ill_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   task automatic fill();
      for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
   endtask

   task automatic assert_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, "_ctl"}, {imem_req, acc_we, rf_we, halted, illegal, imm_sel}, 0);
      check({tag, "_addr"}, imem_addr, 0);
      check({tag, "_sel"}, {alu_sel, alu_rot}, 0);
   endtask

   task automatic release_reset();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      assert_reset(tag);
      release_reset();
   endtask

   task automatic run_to_halt(input string tag);
      int n = 0;
      while (!halted && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_halted"}, halted, 1);
      check({tag, "_req_off"}, imem_req, 0);
      @(negedge clk);
      #1;
   endtask

   int ba, br, bf, bi, n;

   initial begin
      rst_n  = 1'b0;
      wait_n = 0;
      wcnt   = 0;
      az_ovr = 1'b0;
      az_val = 1'b0;

      // 1: LDI 5, ADD R0, STA R1, HLT with zero-wait memory
      fill();
      mem[0] = 8'hB0; mem[1] = 8'h05; mem[2] = 8'h50; mem[3] = 8'h21; mem[4] = 8'hF0;
      ba = acc_log.size(); br = rf_log.size();
      do_reset("rst1");
      n = 0;
      while (!acc_we && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t1_ldi_latency", n, 4);
      run_to_halt("t1");
      check("t1_ldi_sel", qget(acc_log, ba), 32'h901);
      check("t1_add_sel", qget(acc_log, ba + 1), 32'h300);
      check("t1_acc", acc, 8'd8);
      check("t1_sta", qget(rf_log, br), 32'h001);
      check("t1_rf1", rf[1], 8'd8);
      check("t1_we_counts", (acc_log.size() - ba) * 16 + (rf_log.size() - br), 32'h21);

      // 2: INC with 3-cycle fetch waits
      fill();
      mem[0] = 8'h70;
      wait_n = 3;
      ba = acc_log.size();
      do_reset("rst2");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t2_wait_req", imem_req, 1);
         check("t2_wait_addr", imem_addr, 0);
      end
      run_to_halt("t2");
      check("t2_inc", qget(acc_log, ba), 32'h500);
      check("t2_acc_we_cycles", acc_log.size() - ba, 1);
      check("t2_acc", acc, 8'd1);
      wait_n = 0;

      // 3: JZ taken, JZ not taken, JMP
      az_ovr = 1'b1;
      for (int k = 0; k < 3; k++) begin
         fill();
         mem[0] = (k == 2) ? 8'hC0 : 8'hD0;
         mem[1] = (k == 2) ? 8'h80 : 8'h10;
         az_val = (k == 0);
         bf = fetch_log.size();
         do_reset("rst3");
         run_to_halt("t3");
         check("t3_target", qget(fetch_log, bf + 2), (k == 0) ? 32'h10 : (k == 1) ? 32'h02 : 32'h80);
      end
      az_ovr = 1'b0;

      // 4: ROR 3, then illegal opcode
      fill();
      mem[0] = 8'h93;
      ba = acc_log.size();
      do_reset("rst4");
      run_to_halt("t4a");
      check("t4_ror", qget(acc_log, ba), 32'h730);

      fill();
      mem[0] = 8'hE5;
      ba = acc_log.size(); br = rf_log.size(); bf = fetch_log.size(); bi = ill_cnt;
      do_reset("rst4b");
      run_to_halt("t4b");
      check("t4_ill_pulses", ill_cnt - bi, 1);
      check("t4_ill_no_strobe", (acc_log.size() - ba) + (rf_log.size() - br), 0);
      check("t4_ill_next_pc", qget(fetch_log, bf + 1), 1);

      // 5: LDI at 0xFF with immediate wrapping to 0x00
      fill();
      mem[0] = 8'hC0; mem[1] = 8'hFF; mem[8'hFF] = 8'hB0;
      bf = fetch_log.size();
      do_reset("rst5");
      run_to_halt("t5");
      check("t5_ldi_at_ff", qget(fetch_log, bf + 2), 32'hFF);
      check("t5_imm_addr", qget(fetch_log, bf + 3), 0);
      check("t5_next_fetch", qget(fetch_log, bf + 4), 1);
      check("t5_acc", acc, 8'hC0);

      // 6a: reset asserted during FETCH_IMM
      fill();
      mem[0] = 8'hB0; mem[1] = 8'h05;
      wait_n = 2;
      ba = acc_log.size();
      do_reset("rst6");
      n = 0;
      while (!(imem_req && imem_addr == 8'h01) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t6_reach_fetch_imm", n < 50, 1);
      assert_reset("t6a_mid");
      check("t6a_no_acc_we", acc_log.size() - ba, 0);
      wait_n = 0;
      release_reset();
      @(negedge clk);
      check("t6a_refetch_req", imem_req, 1);
      check("t6a_refetch_addr", imem_addr, 0);
      run_to_halt("t6a");

      // 6b: reset asserted during EXECUTE
      fill();
      mem[0] = 8'h70;
      do_reset("rst6b");
      n = 0;
      while (!acc_we && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t6b_reach_exec", acc_we, 1);
      assert_reset("t6b_mid");
      check("t6b_acc_we_low", acc_we, 0);
      release_reset();
      @(negedge clk);
      check("t6b_refetch_addr", {imem_req, imem_addr}, 9'h100);
      run_to_halt("t6b");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
